// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle of the 7-segment scan driver: load/busy handshake,
// live display controls and the board-facing anode/segment pins.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              dec_mode;
  logic              blank_en;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic              overflow;
  logic [DIGITS-1:0] an;
  logic [0:7]        seg;

  modport master (
    output load, value, dec_mode, blank_en, dp_mask,
    input  busy, overflow, an, seg
  );

  modport slave (
    input  load, value, dec_mode, blank_en, dp_mask,
    output busy, overflow, an, seg
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: hex or decimal display of a
// loaded value, with sequential double-dabble conversion, leading-zero
// blanking, per-digit decimal points and overflow dashes.
module seg7_scan_driver #(
  parameter int DIGITS  = 8,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  // One spare BCD digit above the displayed ones catches 10^DIGITS overflow.
  localparam int BCD_W  = 4 * DIGITS + 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TICK_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                busy;
  logic                accept;
  logic                last_shift;

  logic [DATA_W-1:0]   bin;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    shift_cnt;
  logic                lost;
  logic                overflow;
  logic [3:0]          disp [DIGITS];
  logic [4*DIGITS-1:0] hex_wide;

  logic [TICK_W-1:0]   tick;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   leading;
  logic [DIGITS-1:0]   an_next;
  logic [DIGITS-1:0]   an_q;
  logic [0:6]          glyph_next;
  logic [0:7]          seg_next;
  logic [0:7]          seg_q;

  function automatic logic [0:6] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign accept     = (state == IDLE) && bus.load;
  assign last_shift = (shift_cnt == CNT_W'(DATA_W - 1));
  assign hex_wide   = (4 * DIGITS)'(bus.value);

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Only a decimal accept leaves IDLE; hex loads complete in place.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && bus.dec_mode) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy covers the whole conversion, so loads during it are dropped.
  always_comb begin
    busy = (state != IDLE);
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Capture, shift and commit; the visible digits only change at hex accept or DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      lost      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.dec_mode) begin
              bin       <= bus.value;
              bcd       <= '0;
              shift_cnt <= '0;
              lost      <= 1'b0;
            end else begin
              overflow <= 1'b0;
              for (int i = 0; i < DIGITS; i++) disp[i] <= hex_wide[4*i +: 4];
            end
          end
        end
        SHIFT: begin
          bcd       <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
          bin       <= bin << 1;
          shift_cnt <= shift_cnt + CNT_W'(1);
          if (bcd_adj[BCD_W-1]) lost <= 1'b1;
        end
        DONE: begin
          overflow <= lost || (bcd[BCD_W-1 -: 4] != 4'd0);
          for (int i = 0; i < DIGITS; i++) disp[i] <= bcd[4*i +: 4];
        end
        default: ;
      endcase
    end
  end

  // Scan timing: each digit stays selected for CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TICK_W'(CLK_DIV - 1)) begin
      tick <= '0;
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  // leading[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic run;
    run     = 1'b1;
    leading = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run        = run && (disp[i] == 4'd0);
      leading[i] = run;
    end
  end

  // Pin values for the currently selected digit; dp ignores blanking and overflow.
  always_comb begin
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) an_next[i] = 1'b0;
    end
    if (overflow)                                     glyph_next = 7'b1111110;
    else if (bus.blank_en && idx != '0 && leading[idx]) glyph_next = 7'b1111111;
    else                                              glyph_next = glyph(disp[idx]);
    seg_next = {glyph_next, ~bus.dp_mask[idx]};
  end

  // Registered pins keep the display glitch-free; dark until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign bus.busy     = busy;
  assign bus.overflow = overflow;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vector table, hand-written
// timing/reset sequences and randomized loads against an arithmetic model.
module tb_seg7_scan_driver;

  localparam int DIGITS  = 8;
  localparam int DATA_W  = 32;
  localparam int CLK_DIV = 4;

  typedef struct {
    logic [31:0] value;
    bit          dec;
    bit          blank;
    logic [7:0]  dp;
    logic [31:0] exp_digits;
    bit          exp_ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] cur_digits = '0;
  bit          cur_ovf    = 1'b0;
  vec_t        vecs [8];

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_driver_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg7_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Digits shown for a load: raw nibbles in hex, decimal digits otherwise.
  function automatic void model(input logic [31:0] v, input bit dec,
                                output logic [31:0] d, output bit ovf);
    longint unsigned x;
    x = v;
    if (!dec) begin
      d   = v;
      ovf = 1'b0;
    end else begin
      ovf = (x > 64'd99999999);
      d   = '0;
      for (int i = 0; i < 8; i++) begin
        d[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  function automatic logic [7:0] exp_seg(input logic [31:0] digits, input bit ovf,
                                         input bit blank, input logic [7:0] dp, input int idx);
    logic [6:0] g;
    if (ovf)                                          g = 7'b1111110;
    else if (blank && idx != 0 && (digits >> (4*idx)) == 0) g = 7'b1111111;
    else                                              g = glyph_tab[digits[4*idx +: 4]];
    return {g, ~dp[idx]};
  endfunction

  function automatic int an_idx(input logic [7:0] a);
    for (int i = 0; i < DIGITS; i++) if (!a[i]) return i;
    return 0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Visit every digit once in the scan and compare its segments to the model.
  task automatic check_scan(input string tag);
    logic [7:0] seen;
    int cyc;
    int i;
    seen = '0;
    cyc  = 0;
    while (seen != 8'hFF && cyc < 2*DIGITS*CLK_DIV + 8) begin
      @(negedge clk);
      cyc++;
      check_output({tag, "_an_onehot"}, $countones(~bus.an), 1);
      if ($countones(~bus.an) == 1) begin
        i = an_idx(bus.an);
        if (!seen[i]) begin
          check_output($sformatf("%s_dig%0d", tag, i), {24'd0, bus.seg},
                       {24'd0, exp_seg(cur_digits, cur_ovf, bus.blank_en, bus.dp_mask, i)});
          seen[i] = 1'b1;
        end
      end
    end
    check_output({tag, "_scan_cover"}, {24'd0, seen}, 32'hFF);
  endtask

  // One load handshake; for decimal, also times busy and checks the old
  // display is held throughout. pulse_at>0 re-pulses load mid-conversion.
  task automatic apply_stimulus(input string tag, input logic [31:0] v, input bit dec,
                                input bit blank, input logic [7:0] dp,
                                input logic [31:0] exp_digits, input bit exp_ovf,
                                input int pulse_at, input logic [31:0] pulse_val);
    int cnt;
    int i;
    @(negedge clk);
    bus.value    = v;
    bus.dec_mode = dec;
    bus.blank_en = blank;
    bus.dp_mask  = dp;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    if (dec) begin
      cnt = 0;
      while (bus.busy && cnt < 4*DATA_W) begin
        cnt++;
        if ($countones(~bus.an) == 1) begin
          i = an_idx(bus.an);
          check_output($sformatf("%s_hold_dig%0d", tag, i), {24'd0, bus.seg},
                       {24'd0, exp_seg(cur_digits, cur_ovf, blank, dp, i)});
        end
        bus.load = (cnt == pulse_at);
        if (cnt == pulse_at) bus.value = pulse_val;
        @(negedge clk);
      end
      bus.load = 1'b0;
      check_output({tag, "_busy_cycles"}, cnt, DATA_W + 1);
    end else begin
      check_output({tag, "_hex_busy"}, {31'd0, bus.busy}, 32'd0);
    end
    cur_digits = exp_digits;
    cur_ovf    = exp_ovf;
    @(negedge clk);
    check_output({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    check_scan(tag);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] d;
    logic [7:0]  prev;
    logic [7:0]  e;
    bit          o;
    bit          dec;
    int          run;

    vecs[0] = '{32'h00001A2F,    1'b0, 1'b1, 8'h00, 32'h00001A2F, 1'b0};
    vecs[1] = '{32'd12345678,    1'b1, 1'b0, 8'h00, 32'h12345678, 1'b0};
    vecs[2] = '{32'd100000000,   1'b1, 1'b0, 8'hA5, 32'h00000000, 1'b1};
    vecs[3] = '{32'hDEADBEEF,    1'b0, 1'b1, 8'hFF, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{32'd0,           1'b1, 1'b1, 8'h04, 32'h00000000, 1'b0};
    vecs[5] = '{32'd4294967295,  1'b1, 1'b0, 8'h00, 32'h94967295, 1'b1};
    vecs[6] = '{32'd99999999,    1'b1, 1'b1, 8'h81, 32'h99999999, 1'b0};
    vecs[7] = '{32'h00000000,    1'b0, 1'b1, 8'h00, 32'h00000000, 1'b0};

    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dec_mode = 1'b0;
    bus.blank_en = 1'b1;
    bus.dp_mask  = '0;

    // Power-on reset values.
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_output("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check_output("rst_an", {24'd0, bus.an}, 32'hFF);
    check_output("rst_seg", {24'd0, bus.seg}, 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scan cadence: digit 0 first, then one step every CLK_DIV cycles, wrapping.
    @(negedge clk);
    check_output("first_digit", {24'd0, bus.an}, 32'hFE);
    prev = bus.an;
    run  = 1;
    for (int step = 1; step <= DIGITS; step++) begin
      forever begin
        @(negedge clk);
        if (bus.an == prev && run < 10*CLK_DIV) run++;
        else break;
      end
      e = ~(8'd1 << (step % DIGITS));
      check_output($sformatf("dwell%0d", step), run, CLK_DIV);
      check_output($sformatf("an_step%0d", step), {24'd0, bus.an}, {24'd0, e});
      prev = bus.an;
      run  = 1;
    end
    check_scan("after_reset");

    // Directed vector table.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus($sformatf("vec%0d", k), vecs[k].value, vecs[k].dec, vecs[k].blank,
                     vecs[k].dp, vecs[k].exp_digits, vecs[k].exp_ovf, -1, 32'd0);
    end

    // A load pulsed during the conversion must be dropped.
    apply_stimulus("ignore_load", 32'd87654321, 1'b1, 1'b0, 8'h10,
                   32'h87654321, 1'b0, 5, 32'd11111111);

    // Randomized loads against the arithmetic model.
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        default: v = $urandom_range(0, 999);
      endcase
      dec = 1'($urandom_range(0, 1));
      model(v, dec, d, o);
      apply_stimulus($sformatf("rnd%0d", r), v, dec, 1'($urandom_range(0, 1)),
                     8'($urandom), d, o, -1, 32'd0);
    end

    // Reset in the middle of a conversion, starting from an overflowed display.
    apply_stimulus("pre_reset", 32'd4294967295, 1'b1, 1'b1, 8'h00, 32'h94967295, 1'b1, -1, 32'd0);
    @(negedge clk);
    bus.value    = 32'd12345678;
    bus.dec_mode = 1'b1;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (10) @(negedge clk);
    check_output("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_output("mid_rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check_output("mid_rst_an", {24'd0, bus.an}, 32'hFF);
    check_output("mid_rst_seg", {24'd0, bus.seg}, 32'hFF);
    bus.blank_en = 1'b1;
    bus.dp_mask  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("mid_rst_first_digit", {24'd0, bus.an}, 32'hFE);
    cur_digits = '0;
    cur_ovf    = 1'b0;
    check_scan("mid_rst");
    check_output("mid_rst_busy_after", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed driver for a common-anode 7-segment display bank of DIGITS digits, scanned one digit at a time.
- Accepts a DATA_W-bit unsigned value through a load/busy handshake and shows it in hex, or in decimal after a sequential double-dabble binary-to-BCD conversion.
- Adds leading-zero blanking, per-digit decimal points and overflow indication.
- Sits between CPU-visible registers and the board display pins.

Parameters:
- DIGITS, 8: number of display digits; anode width.
- DATA_W, 32: width of the loaded value; must be ≥ 4 and ≤ 4*DIGITS for hex mode (upper hex digits zero-filled).
- CLK_DIV, 100000: clk cycles each digit stays enabled per scan step; ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active low.
- load  input  1  request to capture value/dec_mode; accepted only when busy=0.
- value  input  DATA_W  unsigned number to display.
- dec_mode  input  1  1 = decimal, 0 = hex; sampled with value.
- blank_en  input  1  live; 1 = blank leading zero digits.
- dp_mask  input  DIGITS  live; bit i=1 lights the decimal point of digit i.
- busy  output  1  conversion in progress; load ignored while high.
- overflow  output  1  last accepted decimal value exceeds 10^DIGITS−1.
- an  output  DIGITS  active-low anode enables; exactly one low after reset release.
- seg  output  [0:7]  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- Reset (rst_n=0, async):
  - busy=0, overflow=0.
  - an all ones, seg=8'b11111111.
  - Display digit registers=0; FSM in IDLE; scan index=0; tick counter=0.
- Glyph encoding, seg[0:6] (dp appended from dp_mask):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - dash=1111110, blank=1111111
- FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - load=1 at edge T → capture value, dec_mode.
    - hex mode: display registers take nibbles of value at edge T, overflow←0, stay IDLE, busy stays 0.
    - decimal mode: clear BCD shift register (4*DIGITS+4 bits, one guard digit), go to SHIFT, busy=1 from T.
  - SHIFT: DATA_W cycles; each cycle add 3 to every BCD nibble ≥5, then shift left one bit, MSB of remaining value first. After the last shift go to DONE.
  - DONE, one cycle:
    - overflow←1 if the guard digit is nonzero or any bit beyond DIGITS digits was lost; else 0.
    - Display registers←lower DIGITS BCD digits.
    - Return to IDLE; busy falls.
    - Display updates exactly DATA_W+1 edges after acceptance.
  - load while busy=1: ignored, no queueing.
  - load held high in IDLE: re-accepted each time busy is low.
- Display registers change only at hex accept or DONE, so partial conversions are never shown.
- Scan:
  - Tick counter counts 0..CLK_DIV−1.
  - On terminal count, scan index increments, wrapping DIGITS−1→0.
  - an and seg are registered: they update one cycle after the index changes.
  - an[idx]=0, all others 1.
- Digit content:
  - overflow=1: every digit shows dash.
  - Otherwise glyph of display digit idx.
  - If blank_en=1 and digit idx and all higher digits are zero, a–g are blank. Digit 0 is never blanked.
  - dp (seg[7]) = ~dp_mask[idx], independent of blanking and overflow.
- Reset mid-conversion: aborts; registers return to reset values; the display shows 0 (or digit 0 only if blank_en).

Test Plan:
1. Reset, hex load value=32'h00001A2F, blank_en=1, dp_mask=0 → busy never high; scanning digits 0–3 show F,2,A,1 (seg 0111000_1, 0010010_1, 0001000_1, 1001111_1); digits 4–7 seg=11111111; an steps 11111110→11111101… every CLK_DIV cycles.
2. Decimal load value=32'd12345678 → busy high exactly 33 cycles; then digits 7..0 read 1,2,3,4,5,6,7,8; overflow=0.
3. Decimal load value=32'd100000000 (9 digits) → overflow=1; all digits seg[0:6]=1111110; a following hex load clears overflow.
4. Pulse load during SHIFT with a different value → ignored; result equals the first value; busy timing unchanged.
5. dp_mask=8'b00000100, blank_en=1, value=0 decimal → digit 0 shows 0; digit 2 seg=11111110 (dp only); other digits 11111111.
6. Assert rst_n=0 mid-SHIFT → immediately busy=0, an all ones, seg=11111111; after release scan restarts at digit 0.
